uart_rx_os: RTL and testbench

- Parametrised, oversampled UART receiver; next generation of the single-rate uart_rx.
- Samples rx_serial on an OVERSAMPLE×baud strobe from baud_gen.
- Data width, parity mode and stop-bit count are configurable.
- Reports parity, framing and overrun errors; delivers bytes over a valid/ready handshake to downstream logic (FIFO or CPU register).

---
 rtl/uart_rx_os_pkg.sv | 43 ++++
 rtl/uart_rx_os_if.sv | 28 ++
 rtl/uart_rx_os_sync2.sv | 23 ++
 rtl/uart_rx_os.sv | 230 +++++++++++++++++++++++
 tb/tb_uart_rx_os.sv | 280 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_rx_os_pkg.sv
// uart_pkg: shared types and sizing helpers for the oversampled UART receiver.
//   parity_e    - parity mode selector (none / odd / even)
//   rx_state_e  - receive FSM states; BRK exists only when
//                 UART_RX_BREAK_DETECT_EN is defined
//   tick_cnt_w  - width of the os_tick counter for a given OVERSAMPLE
//   bit_cnt_w   - width of the bit counter for a given DATA_WIDTH
//   to_parity   - maps the integer PARITY parameter onto parity_e
package uart_pkg;

  typedef enum logic [1:0] {
    PAR_NONE,
    PAR_ODD,
    PAR_EVEN
  } parity_e;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PAR,
    STOP
`ifdef UART_RX_BREAK_DETECT_EN
    , BRK
`endif
  } rx_state_e;

  function automatic int tick_cnt_w(input int oversample);
    return (oversample > 1) ? $clog2(oversample) : 1;
  endfunction

  function automatic int bit_cnt_w(input int data_width);
    return $clog2(data_width + 1);
  endfunction

  function automatic parity_e to_parity(input int p);
    case (p)
      1:       return PAR_ODD;
      2:       return PAR_EVEN;
      default: return PAR_NONE;
    endcase
  endfunction

endpackage

// File: rtl/uart_rx_os_if.sv
// uart_rx_os_if: output handshake bundle of the UART receiver.
//   out_ready  - downstream accepts data this cycle
//   data_out   - received payload, LSB received first
//   data_valid - data_out / parity_err / frame_err are valid
//   parity_err - parity mismatch for the held frame
//   frame_err  - a stop bit was sampled low for the held frame
//   overrun    - sticky; a completed frame was dropped
// Modports: master = receiver side, slave = consumer side.
interface uart_rx_os_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  data_valid;
  logic                  parity_err;
  logic                  frame_err;
  logic                  overrun;

  modport master (
    input  out_ready,
    output data_out, data_valid, parity_err, frame_err, overrun
  );

  modport slave (
    output out_ready,
    input  data_out, data_valid, parity_err, frame_err, overrun
  );
endinterface

// File: rtl/uart_rx_os_sync2.sv
// uart_sync2: two-flop synchroniser for an asynchronous, idle-high input.
//   clk - destination clock
//   rst - synchronous active-high reset, both flops reset to 1
//   d   - asynchronous input
//   q   - synchronised output
module uart_sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  logic meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= 1'b1;
      q    <= 1'b1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end
endmodule

// File: rtl/uart_rx_os.sv
// uart_rx_os: oversampled UART receiver with valid/ready output.
//   clk       - system clock
//   rst       - synchronous active-high reset
//   os_tick   - one-clk strobe at OVERSAMPLE x baud
//   rx_serial - asynchronous serial line, idle high
//   rx_if     - uart_rx_os_if.master: out_ready in; data_out, data_valid,
//               parity_err, frame_err, overrun out
//   break_det - (only with UART_RX_BREAK_DETECT_EN) one-clk pulse per break
// Parameters: DATA_WIDTH (5..9), OVERSAMPLE (even, >=4),
//             PARITY (0 none, 1 odd, 2 even), STOP_BITS (1 or 2).
// Optional feature macro: UART_RX_BREAK_DETECT_EN.
module uart_rx_os
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int OVERSAMPLE = 16,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic os_tick,
  input  logic rx_serial,
  uart_rx_os_if.master rx_if
`ifdef UART_RX_BREAK_DETECT_EN
  , output logic break_det
`endif
);

  localparam int      TW    = tick_cnt_w(OVERSAMPLE);
  localparam int      BW    = bit_cnt_w(DATA_WIDTH);
  localparam parity_e PMODE = to_parity(PARITY);

  localparam logic [TW-1:0] TICK_HALF = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_WIDTH - 1);
  localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);

  logic rx_s;

  uart_sync2 u_sync (
    .clk (clk),
    .rst (rst),
    .d   (rx_serial),
    .q   (rx_s)
  );

  rx_state_e             state_q, state_d;
  logic [TW-1:0]         tick_q, tick_d;
  logic [BW-1:0]         bit_q, bit_d;
  logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
  logic                  par_q, par_d;
  logic                  acc_ferr_q, acc_ferr_d;

  logic frame_done;
  logic frame_perr;
  logic frame_ferr;
  logic centre;
`ifdef UART_RX_BREAK_DETECT_EN
  logic brk_hit;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      tick_q     <= '0;
      bit_q      <= '0;
      shreg_q    <= '0;
      par_q      <= 1'b0;
      acc_ferr_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      tick_q     <= tick_d;
      bit_q      <= bit_d;
      shreg_q    <= shreg_d;
      par_q      <= par_d;
      acc_ferr_q <= acc_ferr_d;
    end
  end

  assign centre = (tick_q == TICK_LAST);

  always_comb begin
    state_d    = state_q;
    tick_d     = tick_q;
    bit_d      = bit_q;
    shreg_d    = shreg_q;
    par_d      = par_q;
    acc_ferr_d = acc_ferr_q;
    frame_done = 1'b0;
`ifdef UART_RX_BREAK_DETECT_EN
    brk_hit    = 1'b0;
`endif
    if (os_tick) begin
      unique case (state_q)
        IDLE: begin
          if (!rx_s) begin
            state_d = START;
            tick_d  = '0;
          end
        end
        START: begin
          if (tick_q == TICK_HALF) begin
            if (rx_s) begin
              state_d = IDLE;
            end else begin
              state_d = DATA;
              tick_d  = '0;
              bit_d   = '0;
            end
          end else begin
            tick_d = tick_q + 1'b1;
          end
        end
        DATA: begin
          if (centre) begin
            tick_d  = '0;
            shreg_d = {rx_s, shreg_q[DATA_WIDTH-1:1]};
            if (bit_q == BIT_LAST) begin
              bit_d      = '0;
              par_d      = 1'b0;
              acc_ferr_d = 1'b0;
              state_d    = (PMODE == PAR_NONE) ? STOP : PAR;
            end else begin
              bit_d = bit_q + 1'b1;
            end
          end else begin
            tick_d = tick_q + 1'b1;
          end
        end
        PAR: begin
          if (centre) begin
            tick_d  = '0;
            par_d   = rx_s;
            state_d = STOP;
          end else begin
            tick_d = tick_q + 1'b1;
          end
        end
        STOP: begin
          if (centre) begin
            tick_d = '0;
`ifdef UART_RX_BREAK_DETECT_EN
            // Break: all-zero payload, zero parity and a low first stop bit.
            if (bit_q == '0 && shreg_q == '0 && !rx_s &&
                (PMODE == PAR_NONE || !par_q)) begin
              state_d = BRK;
              brk_hit = 1'b1;
            end else
`endif
            begin
              acc_ferr_d = acc_ferr_q | ~rx_s;
              if (bit_q == STOP_LAST) begin
                // Return to IDLE on this tick so a back-to-back start is seen.
                state_d    = IDLE;
                frame_done = 1'b1;
              end else begin
                bit_d = bit_q + 1'b1;
              end
            end
          end else begin
            tick_d = tick_q + 1'b1;
          end
        end
`ifdef UART_RX_BREAK_DETECT_EN
        BRK: begin
          if (rx_s) state_d = IDLE;
        end
`endif
        default: state_d = IDLE;
      endcase
    end
  end

  // Error status of the frame completing this cycle, including the stop
  // sample taken right now.
  always_comb begin
    frame_ferr = acc_ferr_d;
    unique case (PMODE)
      PAR_ODD:  frame_perr = ~(^shreg_q ^ par_q);
      PAR_EVEN: frame_perr = ^shreg_q ^ par_q;
      default:  frame_perr = 1'b0;
    endcase
  end

  logic [DATA_WIDTH-1:0] data_q;
  logic                  valid_q;
  logic                  perr_q;
  logic                  ferr_q;
  logic                  ovr_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      data_q  <= '0;
      valid_q <= 1'b0;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      if (valid_q && rx_if.out_ready) begin
        valid_q <= 1'b0;
        ovr_q   <= 1'b0;
      end
      if (frame_done) begin
        if (!valid_q || rx_if.out_ready) begin
          data_q  <= shreg_q;
          perr_q  <= frame_perr;
          ferr_q  <= frame_ferr;
          valid_q <= 1'b1;
        end else begin
          ovr_q <= 1'b1;
        end
      end
    end
  end

`ifdef UART_RX_BREAK_DETECT_EN
  always_ff @(posedge clk) begin
    if (rst) break_det <= 1'b0;
    else     break_det <= brk_hit;
  end
`endif

  assign rx_if.data_out   = data_q;
  assign rx_if.data_valid = valid_q;
  assign rx_if.parity_err = perr_q;
  assign rx_if.frame_err  = ferr_q;
  assign rx_if.overrun    = ovr_q;

endmodule

// File: tb/tb_uart_rx_os.sv
module tb_uart_rx_os;

  localparam int TDIV   = 4;            // clk cycles per os_tick
  localparam int OS     = 16;
  localparam int BITCLK = TDIV * OS;    // clk cycles per bit

  logic clk = 1'b0;
  logic rst;
  logic os_tick;
  logic rx_a, rx_b;
  logic rdy;
  int   tdiv;

  uart_rx_os_if #(.DATA_WIDTH(8)) if_a ();
  uart_rx_os_if #(.DATA_WIDTH(8)) if_b ();
  assign if_a.out_ready = rdy;
  assign if_b.out_ready = rdy;

`ifdef UART_RX_BREAK_DETECT_EN
  logic brk_a, brk_b;
`endif

  // DUT A: 8N1, DUT B: 8E1
  uart_rx_os #(.DATA_WIDTH(8), .OVERSAMPLE(OS), .PARITY(0), .STOP_BITS(1)) dut_a (
    .clk(clk), .rst(rst), .os_tick(os_tick), .rx_serial(rx_a), .rx_if(if_a)
`ifdef UART_RX_BREAK_DETECT_EN
    , .break_det(brk_a)
`endif
  );

  uart_rx_os #(.DATA_WIDTH(8), .OVERSAMPLE(OS), .PARITY(2), .STOP_BITS(1)) dut_b (
    .clk(clk), .rst(rst), .os_tick(os_tick), .rx_serial(rx_b), .rx_if(if_b)
`ifdef UART_RX_BREAK_DETECT_EN
    , .break_det(brk_b)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] d;
    logic       pe;
    logic       fe;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];

  int checks = 0;
  int passes = 0;
  int xfer_a = 0;
  int xfer_b = 0;
  int brk_cnt_a = 0;
  int brk_cnt_b = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic bit_time(input int n);
    repeat (n * BITCLK) adv();
  endtask

  initial begin
    os_tick = 1'b0;
    tdiv = 0;
    forever begin
      @(posedge clk);
      #1;
      tdiv = (tdiv + 1) % TDIV;
      os_tick = (tdiv == 0);
    end
  end

  // Reference: parity error for even mode is an odd count of ones over
  // payload plus parity bit; 8N1 never reports one.
  function automatic logic model_perr(input int d, input logic [7:0] data, input logic p);
    if (d == 0) return 1'b0;
    return (($countones(data) + int'(p)) % 2) != 0;
  endfunction

  function automatic logic even_bit(input logic [7:0] data);
    return ($countones(data) % 2) != 0;
  endfunction

  task automatic drive(input int d, input logic v);
    if (d == 0) rx_a = v;
    else        rx_b = v;
  endtask

  // One frame: start, 8 data LSB first, parity (DUT B only), one stop,
  // then one idle bit.
  task automatic send(input int d, input logic [7:0] data, input logic p,
                      input logic stop, input bit push);
    exp_t e;
    logic [7:0] sh;
    if (push) begin
      e.d  = data;
      e.pe = model_perr(d, data, p);
      e.fe = ~stop;
      if (d == 0) q_a.push_back(e);
      else        q_b.push_back(e);
    end
    sh = data;
    drive(d, 1'b0);
    bit_time(1);
    for (int i = 0; i < 8; i++) begin
      drive(d, sh[i]);
      bit_time(1);
    end
    if (d == 1) begin
      drive(d, p);
      bit_time(1);
    end
    drive(d, stop);
    bit_time(1);
    drive(d, 1'b1);
    bit_time(1);
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (if_a.data_valid && if_a.out_ready) begin
        xfer_a++;
        if (q_a.size() == 0) begin
          checks++;
          $display("FAIL a_unexpected: got data %0h, expected no output", if_a.data_out);
        end else begin
          e = q_a.pop_front();
          chk("a_data", 32'(if_a.data_out), 32'(e.d));
          chk("a_perr", 32'(if_a.parity_err), 32'(e.pe));
          chk("a_ferr", 32'(if_a.frame_err), 32'(e.fe));
        end
      end
      if (if_b.data_valid && if_b.out_ready) begin
        xfer_b++;
        if (q_b.size() == 0) begin
          checks++;
          $display("FAIL b_unexpected: got data %0h, expected no output", if_b.data_out);
        end else begin
          e = q_b.pop_front();
          chk("b_data", 32'(if_b.data_out), 32'(e.d));
          chk("b_perr", 32'(if_b.parity_err), 32'(e.pe));
          chk("b_ferr", 32'(if_b.frame_err), 32'(e.fe));
        end
      end
`ifdef UART_RX_BREAK_DETECT_EN
      if (brk_a) brk_cnt_a++;
      if (brk_b) brk_cnt_b++;
`endif
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int n;
    int nb;
    int d;
    logic [7:0] data;
    logic p, stop;

    rst = 1'b1;
    rx_a = 1'b1;
    rx_b = 1'b1;
    rdy = 1'b1;
    repeat (5) adv();
    @(negedge clk);
    chk("rst_valid_a", 32'(if_a.data_valid), 0);
    chk("rst_data_a", 32'(if_a.data_out), 0);
    chk("rst_perr_a", 32'(if_a.parity_err), 0);
    chk("rst_ferr_a", 32'(if_a.frame_err), 0);
    chk("rst_ovr_a", 32'(if_a.overrun), 0);
    chk("rst_valid_b", 32'(if_b.data_valid), 0);
    adv();
    rst = 1'b0;
    bit_time(1);

    // 8N1 basic
    send(0, 8'hA5, 1'b0, 1'b1, 1);

    // Even parity: wrong then correct parity bit
    send(1, 8'h43, 1'b0, 1'b1, 1);
    send(1, 8'h43, 1'b1, 1'b1, 1);

    // Framing error then good frame
    send(0, 8'h72, 1'b0, 1'b0, 1);
    send(0, 8'hE7, 1'b0, 1'b1, 1);

    // False start: 4 os_ticks low
    n = xfer_a;
    rx_a = 1'b0;
    repeat (4 * TDIV) adv();
    rx_a = 1'b1;
    bit_time(2);
    chk("false_start_no_data", 32'(xfer_a), 32'(n));
    send(0, 8'hF4, 1'b0, 1'b1, 1);

    // Overrun: second frame dropped while first is held
    rdy = 1'b0;
    send(0, 8'h11, 1'b0, 1'b1, 1);
    send(0, 8'h22, 1'b0, 1'b1, 0);
    @(negedge clk);
    chk("ovr_valid_held", 32'(if_a.data_valid), 1);
    chk("ovr_data_held", 32'(if_a.data_out), 32'h11);
    chk("ovr_flag_set", 32'(if_a.overrun), 1);
    adv();
    rdy = 1'b1;
    adv();
    rdy = 1'b0;
    @(negedge clk);
    chk("ovr_valid_clear", 32'(if_a.data_valid), 0);
    chk("ovr_flag_clear", 32'(if_a.overrun), 0);
    adv();
    rdy = 1'b1;

`ifdef UART_RX_BREAK_DETECT_EN
    n  = xfer_a;
    nb = brk_cnt_a;
    rx_a = 1'b0;
    bit_time(20);
    rx_a = 1'b1;
    bit_time(2);
    chk("break_one_pulse", 32'(brk_cnt_a - nb), 1);
    chk("break_no_data", 32'(xfer_a), 32'(n));
    chk("break_no_ovr", 32'(if_a.overrun), 0);
    send(0, 8'h5A, 1'b0, 1'b1, 1);
`else
    // All-zero frame with low stop is ordinary data with a framing error
    nb = 0;
    send(0, 8'h00, 1'b0, 1'b0, 1);
    send(0, 8'h5A, 1'b0, 1'b1, 1);
`endif

    // Reset mid-frame: nothing delivered
    n = xfer_a;
    rx_a = 1'b0;
    bit_time(3);
    rst = 1'b1;
    repeat (4) adv();
    rx_a = 1'b1;
    rst = 1'b0;
    bit_time(12);
    chk("midreset_no_data", 32'(xfer_a), 32'(n));
    chk("midreset_valid", 32'(if_a.data_valid), 0);

    // Randomised frames
    for (int i = 0; i < 12; i++) begin
      d    = int'($urandom_range(0, 1));
      data = 8'($urandom);
      stop = ($urandom_range(0, 7) != 0);
      if (data == 8'h00) stop = 1'b1;
      p = even_bit(data);
      if ($urandom_range(0, 3) == 0) p = ~p;
      send(d, data, p, stop, 1);
    end

    bit_time(2);
    chk("queue_a_empty", 32'(q_a.size()), 0);
    chk("queue_b_empty", 32'(q_b.size()), 0);
    chk("no_break_b", 32'(brk_cnt_b), 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
